// File: rtl/sume_axi_pkg.sv
// Shared types for the IPIF-to-AXI4-Lite master bridge: FSM state encoding
// and AXI response codes.
package sume_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Anything other than plain OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    unique case (resp)
      OKAY:                   err = 1'b0;
      EXOKAY, SLVERR, DECERR: err = 1'b1;
      default:                err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sume_axi_master_if_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a register bank (slave).
interface sume_axi_lite_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [1:0]          M_AXI_BRESP;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;
  logic [1:0]          M_AXI_RRESP;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RVALID, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RVALID, M_AXI_RRESP
  );

endinterface

// File: rtl/sume_axi_master_if.sv
// Single-outstanding IPIF command -> AXI4-Lite master bridge.
// Optional SUME_AXI_MASTER_RESP_ERR_EN adds Bus2IP_Mst_Error for non-OKAY responses.
module sume_axi_master_if
  import sume_axi_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  sume_axi_lite_if.master                 m_axi,
  input  logic                            IP2Bus_MstRd_Req,
  input  logic                            IP2Bus_MstWr_Req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   IP2Bus_Mst_Addr,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] IP2Bus_Mst_BE,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   IP2Bus_MstWr_d,
  output logic                            Bus2IP_Mst_CmdAck,
  output logic                            Bus2IP_Mst_Cmplt,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   Bus2IP_MstRd_d
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
  ,
  output logic                            Bus2IP_Mst_Error
`endif
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_t                          r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]               r_wstrb;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_cmdack;
  logic                            r_cmplt;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rd_d;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
  logic                            r_err;
`else
  wire w_unused_resp = ^{m_axi.M_AXI_BRESP, m_axi.M_AXI_RRESP};
`endif

  // A channel counts as done once its VALID is already low or is being accepted now.
  wire w_aw_done = !r_awvalid || m_axi.M_AXI_AWREADY;
  wire w_w_done  = !r_wvalid  || m_axi.M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state   <= ST_IDLE;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_cmdack  <= 1'b0;
      r_cmplt   <= 1'b0;
      r_rd_d    <= '0;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_cmdack <= 1'b0;
      r_cmplt  <= 1'b0;
      unique case (r_state)
        // DONE accepts a new command on its exit edge, exactly like IDLE.
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
          r_err   <= 1'b0;
`endif
          if (IP2Bus_MstWr_Req) begin
            r_awaddr  <= IP2Bus_Mst_Addr;
            r_wdata   <= IP2Bus_MstWr_d;
            r_wstrb   <= IP2Bus_Mst_BE;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_cmdack  <= 1'b1;
            r_state   <= ST_WR;
          end else if (IP2Bus_MstRd_Req) begin
            r_araddr  <= IP2Bus_Mst_Addr;
            r_arvalid <= 1'b1;
            r_cmdack  <= 1'b1;
            r_state   <= ST_RADDR;
          end
        end
        ST_WR: begin
          if (r_awvalid && m_axi.M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi.M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi.M_AXI_BVALID) begin
            r_bready <= 1'b0;
            r_cmplt  <= 1'b1;
            r_state  <= ST_DONE;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
            r_err    <= resp_is_err(m_axi.M_AXI_BRESP);
`endif
          end
        end
        ST_RADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rd_d   <= m_axi.M_AXI_RDATA;
            r_rready <= 1'b0;
            r_cmplt  <= 1'b1;
            r_state  <= ST_DONE;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
            r_err    <= resp_is_err(m_axi.M_AXI_RRESP);
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = r_wstrb;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

  assign Bus2IP_Mst_CmdAck = r_cmdack;
  assign Bus2IP_Mst_Cmplt  = r_cmplt;
  assign Bus2IP_MstRd_d    = r_rd_d;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
  assign Bus2IP_Mst_Error  = r_err;
`endif

endmodule

// File: tb/tb_sume_axi_master_if.sv
// Self-checking bench for sume_axi_master_if: directed vector table, reset
// abort sequence and randomized transactions against a transaction-level model.
module tb_sume_axi_master_if;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SW    = DW / 8;
  localparam int BOUND = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sume_axi_lite_if #(.DATA_W(DW), .ADDR_W(AW)) axi ();

  logic          rd_req, wr_req;
  logic [AW-1:0] addr;
  logic [SW-1:0] be;
  logic [DW-1:0] wdata;
  logic          cmdack, cmplt;
  logic [DW-1:0] rd_d;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
  logic          err;
`endif

  sume_axi_master_if #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .M_AXI_ACLK        (clk),
    .M_AXI_ARESETN     (rst_n),
    .m_axi             (axi),
    .IP2Bus_MstRd_Req  (rd_req),
    .IP2Bus_MstWr_Req  (wr_req),
    .IP2Bus_Mst_Addr   (addr),
    .IP2Bus_Mst_BE     (be),
    .IP2Bus_MstWr_d    (wdata),
    .Bus2IP_Mst_CmdAck (cmdack),
    .Bus2IP_Mst_Cmplt  (cmplt),
    .Bus2IP_MstRd_d    (rd_d)
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
    ,
    .Bus2IP_Mst_Error  (err)
`endif
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    int          aw_d;
    int          w_d;
    int          b_d;
    int          ar_d;
    int          r_d;
    logic [31:0] rdat;
    logic [1:0]  resp;
    bit          spurious;
    int          exp_cyc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int txn_id = 0;
  logic [DW-1:0] model_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion cycle, counted from the cycle in which CmdAck is high (cycle 0).
  function automatic int model_cmplt_cycle(input bit wr, input int aw_d, input int w_d,
                                           input int b_d, input int ar_d, input int r_d);
    int m;
    if (wr) begin
      m = (aw_d > w_d) ? aw_d : w_d;
      return m + 2 + b_d;
    end
    return ar_d + 2 + r_d;
  endfunction

  task automatic slave_idle();
    axi.M_AXI_AWREADY = 1'b0;
    axi.M_AXI_WREADY  = 1'b0;
    axi.M_AXI_BVALID  = 1'b0;
    axi.M_AXI_BRESP   = 2'b00;
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RDATA   = '0;
    axi.M_AXI_RRESP   = 2'b00;
  endtask

  task automatic run_txn(input vec_t v);
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, ack_n = 0, cmplt_n = 0;
    int ack_cyc = -1, cmplt_cyc = -1, hs_cyc = -1, arhs_cyc = -1;
    logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0, cmplt_rd = '0;
    logic [3:0]  got_wstrb = '0;
    logic        cmplt_err = 1'b0;
    bit          stable_ok = 1'b1;
    bit          is_wr = v.wr;

    @(negedge clk);
    wr_req = v.wr; rd_req = v.rd; addr = v.a; wdata = v.d; be = v.b;
    @(negedge clk);
    // Scramble command inputs so only registered copies can appear on the bus.
    addr = $urandom; wdata = $urandom; be = 4'($urandom);
    for (int cyc = 0; cyc < BOUND; cyc++) begin
      wr_req = v.spurious && (cyc == 1);
      rd_req = v.spurious && (cyc == 1);
      axi.M_AXI_AWREADY = (cyc >= v.aw_d);
      axi.M_AXI_WREADY  = (cyc >= v.w_d);
      axi.M_AXI_ARREADY = (cyc >= v.ar_d);
      axi.M_AXI_BVALID  = (hs_cyc >= 0) && (b_n == 0) && (cyc >= hs_cyc + 1 + v.b_d);
      axi.M_AXI_RVALID  = (arhs_cyc >= 0) && (r_n == 0) && (cyc >= arhs_cyc + 1 + v.r_d);
      axi.M_AXI_BRESP   = v.resp;
      axi.M_AXI_RRESP   = v.resp;
      axi.M_AXI_RDATA   = axi.M_AXI_RVALID ? v.rdat : $urandom;

      if (cmdack) begin ack_n++; ack_cyc = cyc; end
      if (axi.M_AXI_AWVALID) begin
        if (axi.M_AXI_AWADDR !== v.a) stable_ok = 1'b0;
        if (axi.M_AXI_AWREADY) begin aw_n++; got_awaddr = axi.M_AXI_AWADDR; end
      end
      if (axi.M_AXI_WVALID) begin
        if (axi.M_AXI_WDATA !== v.d || axi.M_AXI_WSTRB !== v.b) stable_ok = 1'b0;
        if (axi.M_AXI_WREADY) begin
          w_n++; got_wdata = axi.M_AXI_WDATA; got_wstrb = axi.M_AXI_WSTRB;
        end
      end
      if (aw_n > 0 && w_n > 0 && hs_cyc < 0) hs_cyc = cyc;
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) b_n++;
      if (axi.M_AXI_ARVALID) begin
        if (axi.M_AXI_ARADDR !== v.a) stable_ok = 1'b0;
        if (axi.M_AXI_ARREADY) begin
          ar_n++; got_araddr = axi.M_AXI_ARADDR;
          if (arhs_cyc < 0) arhs_cyc = cyc;
        end
      end
      if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) r_n++;
      if (cmplt) begin
        cmplt_n++; cmplt_cyc = cyc; cmplt_rd = rd_d;
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
        cmplt_err = err;
`endif
      end
      if (cmplt_n > 0 && cyc >= cmplt_cyc + 2) break;
      @(negedge clk);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    slave_idle();

    check("ack_count", 64'(ack_n), 64'd1);
    check("ack_cycle", 64'(ack_cyc), 64'd0);
    check("cmplt_count", 64'(cmplt_n), 64'd1);
    check("cmplt_cycle", 64'(cmplt_cyc), 64'(v.exp_cyc));
    check("bus_stable", 64'(stable_ok), 64'd1);
    if (is_wr) begin
      check("aw_count", 64'(aw_n), 64'd1);
      check("w_count", 64'(w_n), 64'd1);
      check("b_count", 64'(b_n), 64'd1);
      check("ar_count", 64'(ar_n), 64'd0);
      check("awaddr", 64'(got_awaddr), 64'(v.a));
      check("wdata", 64'(got_wdata), 64'(v.d));
      check("wstrb", 64'(got_wstrb), 64'(v.b));
    end else begin
      check("ar_count", 64'(ar_n), 64'd1);
      check("r_count", 64'(r_n), 64'd1);
      check("aw_count", 64'(aw_n), 64'd0);
      check("w_count", 64'(w_n), 64'd0);
      check("araddr", 64'(got_araddr), 64'(v.a));
      check("rd_at_cmplt", 64'(cmplt_rd), 64'(v.rdat));
      model_rd = v.rdat;
    end
    check("rd_hold", 64'(rd_d), 64'(model_rd));
`ifdef SUME_AXI_MASTER_RESP_ERR_EN
    check("error", 64'(cmplt_err), 64'(v.resp != 2'b00));
`else
    cmplt_err = 1'b0;
`endif
    $display("txn %0d wr=%0d rd=%0d addr=%08h cmplt_cyc=%0d exp_cyc=%0d rd_d=%08h",
             txn_id, v.wr, v.rd, v.a, cmplt_cyc, v.exp_cyc, rd_d);
    txn_id++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                               axi.M_AXI_ARVALID, axi.M_AXI_RREADY, cmdack, cmplt,
                               axi.M_AXI_WSTRB}), 64'd0);
    check({tag, "_addr"}, {axi.M_AXI_AWADDR, axi.M_AXI_ARADDR}, 64'd0);
    check({tag, "_data"}, {axi.M_AXI_WDATA, rd_d}, 64'd0);
  endtask

  vec_t vecs[7];
  vec_t rv;
  bit   cmplt_in_rst;

  initial begin
    rd_req = 1'b0; wr_req = 1'b0; addr = '0; be = '0; wdata = '0;
    slave_idle();

    vecs[0] = '{1, 0, 32'h44000010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 2};
    vecs[1] = '{0, 1, 32'h00000020, 32'h0,        4'h0, 0, 0, 0, 0, 5, 32'h12345678, 2'b00, 0, 7};
    vecs[2] = '{1, 0, 32'h00000100, 32'h0000A5A5, 4'h3, 0, 3, 0, 0, 0, 32'h0,        2'b00, 0, 5};
    vecs[3] = '{1, 1, 32'h00000008, 32'h00000055, 4'hC, 0, 0, 0, 0, 0, 32'h0,        2'b00, 0, 2};
    vecs[4] = '{1, 0, 32'h00000200, 32'h01020304, 4'h5, 0, 0, 2, 0, 0, 32'h0,        2'b00, 1, 4};
    vecs[5] = '{0, 1, 32'h00000030, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 2'b10, 0, 2};
    vecs[6] = '{0, 1, 32'h00000034, 32'h0,        4'h0, 0, 0, 0, 2, 0, 32'h0BADCAFE, 2'b00, 0, 4};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Abort a write while it waits in WRESP.
    @(negedge clk);
    wr_req = 1'b1; addr = 32'h000000F0; wdata = 32'h11112222; be = 4'hF;
    @(negedge clk);
    wr_req = 1'b0;
    axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1;
    @(negedge clk);
    check("wresp_bready", 64'(axi.M_AXI_BREADY), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_rd = '0;
    cmplt_in_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cmplt) cmplt_in_rst = 1'b1;
    end
    check("no_cmplt_in_reset", 64'(cmplt_in_rst), 64'd0);
    slave_idle();
    rst_n = 1'b1;
    @(negedge clk);
    run_txn('{1, 0, 32'h000000F4, 32'h33334444, 4'hA, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 2});

    for (int n = 0; n < 40; n++) begin
      rv.wr       = 1'($urandom_range(0, 1));
      rv.rd       = 1'($urandom_range(0, 1));
      if (!rv.wr && !rv.rd) rv.rd = 1'b1;
      rv.a        = $urandom;
      rv.d        = $urandom;
      rv.b        = 4'($urandom);
      rv.aw_d     = $urandom_range(0, 4);
      rv.w_d      = $urandom_range(0, 4);
      rv.b_d      = $urandom_range(0, 4);
      rv.ar_d     = $urandom_range(0, 4);
      rv.r_d      = $urandom_range(0, 4);
      rv.rdat     = $urandom;
      rv.resp     = 2'($urandom);
      rv.spurious = 1'($urandom_range(0, 1));
      rv.exp_cyc  = model_cmplt_cycle(rv.wr, rv.aw_d, rv.w_d, rv.b_d, rv.ar_d, rv.r_d);
      run_txn(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
